// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encodings and bus-level constants,
// used by i2c_slave and by anything that talks to the i2c_master.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } i2c_state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;
    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;

endpackage

// File: rtl/i2c_edge_sync.sv
// Multi-flop synchroniser for one bus line plus single-cycle rise/fall flags.
// Resets to 1 because an idle I2C line is pulled high.
module i2c_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_line};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: detects START/STOP on oversampled SCL/SDA, ACKs SLAVE_ADDR, delivers
// write bytes on dout and serialises din on reads. SDA is only ever pulled low.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] din,
    output logic       din_req,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       busy
);

    i2c_state_e r_state, w_state_nxt;
    logic [6:0] r_rx;
    logic [6:0] r_tx;
    logic [7:0] r_dout;
    logic [2:0] r_count;
    logic       r_sda_oe, r_dout_valid, r_rw, r_ack_phase;
    logic       w_scl, w_scl_rise, w_scl_fall;
    logic       w_sda, w_sda_rise, w_sda_fall;
    logic       w_start, w_stop, w_last;

    i2c_edge_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .reset(reset), .i_line(SCL),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_edge_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .reset(reset), .i_line(SDA),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    assign w_last  = (r_count == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // START/STOP are tested first so they win over a same-cycle SCL edge.
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ADDR;
        end else if (w_stop) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                ADDR:     if (w_scl_rise && w_last)
                              w_state_nxt = (r_rx == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (w_scl_fall && r_ack_phase)
                              w_state_nxt = (r_rw == RW_READ) ? RD_DATA : WR_DATA;
                WR_DATA:  if (w_scl_rise && w_last) w_state_nxt = WR_ACK;
                WR_ACK:   if (w_scl_fall && r_ack_phase) w_state_nxt = WR_DATA;
                RD_DATA:  if (w_scl_fall && r_count == 3'd0) w_state_nxt = RD_ACK;
                RD_ACK: begin
                    if (w_scl_rise && w_sda == NACK)        w_state_nxt = WAIT_STOP;
                    else if (w_scl_fall && r_ack_phase)     w_state_nxt = RD_DATA;
                end
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        busy    = r_state inside {ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK};
        din_req = 1'b0;
        if (!reset && !w_start && !w_stop && w_scl_fall && r_ack_phase)
            din_req = (r_state == ADDR_ACK && r_rw == RW_READ) || (r_state == RD_ACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx         <= '0;
            r_tx         <= '0;
            r_dout       <= '0;
            r_count      <= '0;
            r_sda_oe     <= 1'b0;
            r_dout_valid <= 1'b0;
            r_rw         <= RW_WRITE;
            r_ack_phase  <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            if (w_state_nxt != r_state) r_ack_phase <= 1'b0;
            if (w_start || w_stop) begin
                r_count  <= '0;
                r_sda_oe <= 1'b0;
            end else begin
                case (r_state)
                    ADDR, WR_DATA: begin
                        if (w_scl_rise) begin
                            r_rx    <= {r_rx[5:0], w_sda};
                            r_count <= r_count + 3'd1;
                            if (w_last && r_state == ADDR) r_rw <= w_sda;
                            if (w_last && r_state == WR_DATA) begin
                                r_dout       <= {r_rx, w_sda};
                                r_dout_valid <= 1'b1;
                            end
                        end
                    end
                    ADDR_ACK, WR_ACK: begin
                        // First SCL fall drives the ACK, the second ends the ACK bit.
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                r_sda_oe    <= 1'b1;
                                r_ack_phase <= 1'b1;
                            end else begin
                                r_sda_oe    <= 1'b0;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (w_scl_rise) r_count <= r_count + 3'd1;
                        if (w_scl_fall) begin
                            if (r_count == 3'd0) begin
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_sda_oe <= ~r_tx[6];
                                r_tx     <= {r_tx[5:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: if (w_scl_rise && w_sda == ACK) r_ack_phase <= 1'b1;
                    default: r_sda_oe <= 1'b0;
                endcase
                if (din_req) begin
                    r_tx     <= din[6:0];
                    r_sda_oe <= ~din[7];
                end
            end
        end
    end

    assign SDA        = r_sda_oe ? 1'b0 : 1'bz;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master, a table of write transfers and
// hand-written read, repeated-START, aborted-write and reset sequences.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 10;

    logic       clk;
    logic       reset;
    logic       SCL;
    logic       m_sda_oe;
    logic [7:0] din;
    logic       din_req;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;
    wire        SDA;

    pullup (SDA);
    assign SDA = m_sda_oe ? 1'b0 : 1'bz;

    i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .SCL(SCL), .SDA(SDA), .din(din),
        .din_req(din_req), .dout(dout), .dout_valid(dout_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int dv_cnt = 0, req_cnt = 0, busy_cnt = 0, drv_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (dout_valid) dv_cnt++;
        if (din_req) req_cnt++;
        if (busy) busy_cnt++;
        if (SDA == 1'b0 && !m_sda_oe) drv_cnt++;
    end

    int n_checks = 0, n_pass = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_cond();
        m_sda_oe = 1'b0; wait_clks(Q);
        SCL = 1'b1;      wait_clks(Q);
        m_sda_oe = 1'b1; wait_clks(Q);
        SCL = 1'b0;      wait_clks(Q);
    endtask

    task automatic stop_cond();
        m_sda_oe = 1'b1; wait_clks(Q);
        SCL = 1'b1;      wait_clks(Q);
        m_sda_oe = 1'b0; wait_clks(Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda_oe = ~b;
        wait_clks(Q);
        SCL = 1'b1;
        wait_clks(Q / 2);
        s = SDA;
        wait_clks(Q / 2);
        SCL = 1'b0;
        wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(ack, s);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_dout;
        int         exp_dv;
    } wr_vec_t;

    wr_vec_t    vecs[5];
    logic       a_ack, d_ack, s;
    logic [7:0] rd;
    logic [7:0] exp_dout;
    int         b_dv, b_req, b_busy, b_drv;

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish within 50000 clocks");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{addr: 7'h50, data: 8'hA5, exp_ack: ACK,  exp_dout: 8'hA5, exp_dv: 1};
        vecs[1] = '{addr: 7'h51, data: 8'h3C, exp_ack: NACK, exp_dout: 8'hA5, exp_dv: 0};
        vecs[2] = '{addr: 7'h50, data: 8'h00, exp_ack: ACK,  exp_dout: 8'h00, exp_dv: 1};
        vecs[3] = '{addr: 7'h50, data: 8'hFF, exp_ack: ACK,  exp_dout: 8'hFF, exp_dv: 1};
        vecs[4] = '{addr: 7'h10, data: 8'h77, exp_ack: NACK, exp_dout: 8'hFF, exp_dv: 0};

        reset = 1'b1; SCL = 1'b1; m_sda_oe = 1'b0; din = 8'h00;
        wait_clks(5);
        check("reset sda", SDA, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset din_req", din_req, 1'b0);
        check("reset dout_valid", dout_valid, 1'b0);
        check("reset dout", dout, 8'h00);
        reset = 1'b0;
        wait_clks(Q);

        // Table of complete write transfers, matching and mismatching addresses.
        for (int v = 0; v < 5; v++) begin
            b_dv = dv_cnt; b_busy = busy_cnt; b_drv = drv_cnt;
            start_cond();
            write_byte({vecs[v].addr, RW_WRITE}, a_ack);
            write_byte(vecs[v].data, d_ack);
            stop_cond();
            wait_clks(Q);
            check($sformatf("v%0d addr ack", v), a_ack, vecs[v].exp_ack);
            check($sformatf("v%0d data ack", v), d_ack, vecs[v].exp_ack);
            check($sformatf("v%0d dout", v), dout, vecs[v].exp_dout);
            check($sformatf("v%0d dout_valid pulses", v), dv_cnt - b_dv, vecs[v].exp_dv);
            check($sformatf("v%0d busy seen", v), busy_cnt != b_busy, vecs[v].exp_ack == ACK);
            check($sformatf("v%0d slave drove sda", v), drv_cnt != b_drv, vecs[v].exp_ack == ACK);
            check($sformatf("v%0d busy after stop", v), busy, 1'b0);
        end
        exp_dout = 8'hFF;

        // Two-byte read: master ACKs the first byte and NACKs the second.
        b_req = req_cnt; b_dv = dv_cnt;
        din = 8'h3C;
        start_cond();
        write_byte({7'h50, RW_READ}, a_ack);
        check("rd addr ack", a_ack, ACK);
        check("rd busy", busy, 1'b1);
        din = 8'h81;
        read_byte(ACK, rd);
        check("rd byte0", rd, 8'h3C);
        read_byte(NACK, rd);
        check("rd byte1", rd, 8'h81);
        wait_clks(Q);
        check("rd din_req pulses", req_cnt - b_req, 2);
        check("rd sda released after nack", SDA, 1'b1);
        check("rd busy after nack", busy, 1'b0);
        stop_cond();
        check("rd dout untouched", dout, exp_dout);
        check("rd no dout_valid", dv_cnt - b_dv, 0);

        // Write then repeated START into a read, no STOP in between.
        b_dv = dv_cnt;
        din = 8'hF0;
        start_cond();
        write_byte({7'h50, RW_WRITE}, a_ack);
        write_byte(8'h12, d_ack);
        check("sr wr addr ack", a_ack, ACK);
        check("sr wr data ack", d_ack, ACK);
        start_cond();
        write_byte({7'h50, RW_READ}, a_ack);
        check("sr rd addr ack", a_ack, ACK);
        read_byte(NACK, rd);
        check("sr rd byte", rd, 8'hF0);
        stop_cond();
        wait_clks(Q);
        check("sr dout", dout, 8'h12);
        check("sr dout_valid pulses", dv_cnt - b_dv, 1);
        check("sr busy after stop", busy, 1'b0);
        exp_dout = 8'h12;

        // STOP after four data bits discards the partial byte.
        b_dv = dv_cnt;
        start_cond();
        write_byte({7'h50, RW_WRITE}, a_ack);
        check("abort addr ack", a_ack, ACK);
        clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
        stop_cond();
        wait_clks(Q);
        check("abort no dout_valid", dv_cnt - b_dv, 0);
        check("abort dout held", dout, exp_dout);
        check("abort busy", busy, 1'b0);
        check("abort sda", SDA, 1'b1);

        // Reset while the target is driving a 0 read bit, then a normal write.
        din = 8'h3C;
        start_cond();
        write_byte({7'h50, RW_READ}, a_ack);
        check("rst addr ack", a_ack, ACK);
        check("rst sda driven low", SDA, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst sda released", SDA, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst din_req", din_req, 1'b0);
        check("rst dout_valid", dout_valid, 1'b0);
        check("rst dout", dout, 8'h00);
        wait_clks(3);
        reset = 1'b0;
        wait_clks(Q);
        b_dv = dv_cnt;
        start_cond();
        write_byte({7'h50, RW_WRITE}, a_ack);
        write_byte(8'h5A, d_ack);
        stop_cond();
        wait_clks(Q);
        check("post-rst addr ack", a_ack, ACK);
        check("post-rst data ack", d_ack, ACK);
        check("post-rst dout", dout, 8'h5A);
        check("post-rst dout_valid pulses", dv_cnt - b_dv, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
